// File: rtl/data_route_pkg.sv
// Shared constants for the 128-bit <-> 1536-bit AXI-Stream width converters
// on the data-route path (used by both the upconverter and the downconverter).
package data_route_pkg;

  localparam int AXIS_NARROW_W = 128;
  localparam int AXIS_RATIO    = 12;
  localparam int AXIS_WIDE_W   = AXIS_NARROW_W * AXIS_RATIO;
  localparam int AXIS_CNT_W    = $clog2(AXIS_RATIO);

endpackage : data_route_pkg

// File: rtl/axis_reg_slice.sv
// Single output register stage for an AXI-Stream master port: holds one word
// plus its tlast vector until the downstream handshake completes.
module axis_reg_slice
  import data_route_pkg::*;
#(
  parameter int DATA_W = AXIS_WIDE_W,
  parameter int LAST_W = AXIS_RATIO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LAST_W-1:0] last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LAST_W-1:0] last_o,
  output logic              free_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [LAST_W-1:0] last_q,  last_d;

  assign free_o = ~valid_q | ready_i;

  // A load wins over a same-cycle drain so back-to-back words keep valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule : axis_reg_slice

// File: rtl/in128_out1536.sv
// AXI-Stream width upconverter: packs RATIO narrow beats into one wide word,
// carrying each beat's tlast in the matching bit of m_axis_tlast.
module in128_out1536
  import data_route_pkg::*;
#(
  parameter int IN_W          = AXIS_NARROW_W,
  parameter int RATIO         = AXIS_RATIO,
  parameter int CNT_W         = AXIS_CNT_W,  // must equal $clog2(RATIO)
  parameter bit FLUSH_ON_LAST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [IN_W*RATIO-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [RATIO-1:0]      m_axis_tlast
);

  localparam int OUT_W = IN_W * RATIO;

  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [OUT_W-1:0] acc_q,      acc_d;
  logic [RATIO-1:0] acc_last_q, acc_last_d;

  logic [OUT_W-1:0] word_s;
  logic [RATIO-1:0] word_last_s;
  logic             closing_s;
  logic             accept_s;
  logic             out_free_s;

  assign closing_s     = (cnt_q == CNT_W'(RATIO - 1)) | (FLUSH_ON_LAST & s_axis_tlast);
  assign s_axis_tready = ~(closing_s & ~out_free_s);
  assign accept_s      = s_axis_tvalid & s_axis_tready;

  // Accumulator with the current beat merged into lane cnt; lanes above cnt
  // are forced to zero so an early flush emits a clean upper part.
  always_comb begin
    word_s      = '0;
    word_last_s = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (CNT_W'(k) == cnt_q) begin
        word_s[k*IN_W +: IN_W] = s_axis_tdata;
        word_last_s[k]         = s_axis_tlast;
      end else if (CNT_W'(k) < cnt_q) begin
        word_s[k*IN_W +: IN_W] = acc_q[k*IN_W +: IN_W];
        word_last_s[k]         = acc_last_q[k];
      end else begin
        word_s[k*IN_W +: IN_W] = '0;
        word_last_s[k]         = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    acc_last_d = acc_last_q;
    if (accept_s) begin
      if (closing_s) begin
        cnt_d      = '0;
        acc_d      = '0;
        acc_last_d = '0;
      end else begin
        cnt_d      = cnt_q + CNT_W'(1);
        acc_d      = word_s;
        acc_last_d = word_last_s;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      acc_last_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      acc_last_q <= acc_last_d;
    end
  end

  axis_reg_slice #(
    .DATA_W (OUT_W),
    .LAST_W (RATIO)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept_s & closing_s),
    .data_i  (word_s),
    .last_i  (word_last_s),
    .ready_i (m_axis_tready),
    .valid_o (m_axis_tvalid),
    .data_o  (m_axis_tdata),
    .last_o  (m_axis_tlast),
    .free_o  (out_free_s)
  );

endmodule : in128_out1536

// File: tb/tb_in128_out1536.sv
// Self-checking bench for in128_out1536: a beat-grouping scoreboard model plus
// directed and randomized traffic on a default and a flush-on-last instance.
module tb_in128_out1536;

  logic          clk;
  logic          rst;
  logic [127:0]  s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          m_ready;
  logic          sel;      // 0: default instance, 1: FLUSH_ON_LAST instance
  logic          rdy_rand;

  logic          tready0, tready1, mvalid0, mvalid1;
  logic [1535:0] mdata0, mdata1;
  logic [11:0]   mlast0, mlast1;

  logic          tready_s, mvalid_s;
  logic [1535:0] mdata_s;
  logic [11:0]   mlast_s;

  int checks = 0;
  int errors = 0;

  logic [127:0]  part_d[$];
  logic          part_l[$];
  logic [1535:0] exp_d[$];
  logic [11:0]   exp_l[$];

  in128_out1536 u_dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid & ~sel), .s_axis_tready(tready0),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(mdata0), .m_axis_tvalid(mvalid0), .m_axis_tready(m_ready),
    .m_axis_tlast(mlast0)
  );

  in128_out1536 #(.FLUSH_ON_LAST(1'b1)) u_flush (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid & sel), .s_axis_tready(tready1),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(mdata1), .m_axis_tvalid(mvalid1), .m_axis_tready(m_ready),
    .m_axis_tlast(mlast1)
  );

  assign tready_s = sel ? tready1 : tready0;
  assign mvalid_s = sel ? mvalid1 : mvalid0;
  assign mdata_s  = sel ? mdata1  : mdata0;
  assign mlast_s  = sel ? mlast1  : mlast0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [1535:0] act, input logic [1535:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < 12; k++) begin
        if (act[k*128 +: 128] !== exp[k*128 +: 128]) begin
          $display("FAIL %s: lane %0d got %h expected %h", name, k,
                   act[k*128 +: 128], exp[k*128 +: 128]);
          break;
        end
      end
    end
  endtask

  // Model: group accepted beats into words of 12, or up to a tlast when flushing.
  task automatic model_accept(input logic [127:0] d, input logic l);
    logic [1535:0] w;
    logic [11:0]   wl;
    part_d.push_back(d);
    part_l.push_back(l);
    if (part_d.size() == 12 || (sel && l)) begin
      w  = '0;
      wl = '0;
      for (int k = 0; k < part_d.size(); k++) begin
        w[k*128 +: 128] = part_d[k];
        wl[k]           = part_l[k];
      end
      exp_d.push_back(w);
      exp_l.push_back(wl);
      part_d.delete();
      part_l.delete();
    end
  endtask

  // Present one beat and wait (bounded) for its handshake; returns stall cycles.
  task automatic send_beat(input logic [127:0] d, input logic l, output int waited);
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (tready_s) break;
      waited++;
      if (waited > 200) break;
    end
    if (waited > 200) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: tready stayed %0b after %0d cycles, expected 1", tready_s, waited);
      s_tvalid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      model_accept(d, l);
      s_tvalid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_d.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (exp_d.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words still pending, expected 0", exp_d.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rep8(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard compare plus output-stability check on every non-reset cycle.
  logic          hold_q;
  logic [1535:0] prev_d;
  logic [11:0]   prev_l;
  always @(negedge clk) begin
    if (rst) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk("hold_valid", 128'(mvalid_s), 128'd1);
        chk_wide("hold_data", mdata_s, prev_d);
        chk("hold_last", 128'(mlast_s), 128'(prev_l));
      end
      if (mvalid_s && m_ready) begin
        if (exp_d.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: output valid with empty expected queue");
        end else begin
          chk_wide("word_data", mdata_s, exp_d.pop_front());
          chk("word_last", 128'(mlast_s), 128'(exp_l.pop_front()));
        end
      end
      hold_q = mvalid_s && !m_ready;
      prev_d = mdata_s;
      prev_l = mlast_s;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [1535:0] lit;
    logic [11:0]   lv;
    rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    m_ready = 1'b1; sel = 1'b0; rdy_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_mvalid", 128'(mvalid0), 128'd0);
    chk_wide("rst_mdata", mdata0, '0);
    chk("rst_mlast", 128'(mlast0), 128'd0);
    chk("rst_tready", 128'(tready0), 128'd1);
    @(posedge clk); #1;

    // Lane k = k, tlast on beat 11
    for (int k = 0; k < 11; k++) send_beat(rep8(8'(k)), 1'b0, w);
    @(negedge clk);
    chk("pre_close_mvalid", 128'(mvalid0), 128'd0);
    @(posedge clk); #1;
    send_beat(rep8(8'd11), 1'b1, w);
    @(negedge clk);
    chk("lat_mvalid", 128'(mvalid0), 128'd1);
    chk("lat_mlast", 128'(mlast0), 128'h800);
    chk("lat_lane5", mdata0[5*128 +: 128], 128'h05050505050505050505050505050505);
    chk("lat_lane11", mdata0[11*128 +: 128], 128'h0b0b0b0b0b0b0b0b0b0b0b0b0b0b0b0b);
    @(posedge clk); #1;
    wait_drain();

    // 36 back-to-back beats: tready never drops
    for (int k = 0; k < 36; k++) begin
      send_beat(rnd128(), 1'($urandom_range(0, 1)), w);
      chk("b2b_no_stall", 128'(w), 128'd0);
    end
    wait_drain();

    // Stall: downstream not ready after first word
    m_ready = 1'b0;
    for (int k = 0; k < 12; k++) send_beat(rnd128(), 1'b0, w);
    for (int k = 0; k < 11; k++) begin
      send_beat(rnd128(), 1'($urandom_range(0, 1)), w);
      chk("stall_nonclosing_accept", 128'(w), 128'd0);
    end
    s_tdata = rnd128(); s_tlast = 1'b1; s_tvalid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stall_tready_low", 128'(tready0), 128'd0);
      chk("stall_mvalid", 128'(mvalid0), 128'd1);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    send_beat(s_tdata, 1'b1, w);
    wait_drain();

    // Reset mid-word discards partial beats
    for (int k = 0; k < 7; k++) send_beat(rnd128(), 1'b0, w);
    rst = 1'b1;
    part_d.delete(); part_l.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_mvalid", 128'(mvalid0), 128'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 12; k++) send_beat({32{4'hA}}, 1'(k == 11), w);
    @(negedge clk);
    lit = {12{ {32{4'hA}} }};
    chk_wide("midrst_word", mdata0, lit);
    chk("midrst_last", 128'(mlast0), 128'h800);
    @(posedge clk); #1;
    wait_drain();

    // Flush-on-last instance: 5 beats, tlast on beat 4
    sel = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) send_beat(rep8(8'hB0 + 8'(k)), 1'(k == 4), w);
    @(negedge clk);
    chk("flush_mvalid", 128'(mvalid1), 128'd1);
    chk("flush_mlast", 128'(mlast1), 128'h010);
    chk("flush_lane4", mdata1[4*128 +: 128], 128'hb4b4b4b4b4b4b4b4b4b4b4b4b4b4b4b4);
    chk("flush_lane5_zero", mdata1[5*128 +: 128], 128'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) send_beat(rep8(8'hC0 + 8'(k)), 1'(k == 2), w);
    @(negedge clk);
    chk("flush2_mlast", 128'(mlast1), 128'h004);
    chk("flush2_lane0", mdata1[127:0], 128'hc0c0c0c0c0c0c0c0c0c0c0c0c0c0c0c0);
    @(posedge clk); #1;
    wait_drain();
    sel = 1'b0;
    @(posedge clk); #1;

    // Loopback-style traffic: 100 random words split into beats with gaps
    rdy_rand = 1'b1;
    for (int n = 0; n < 100; n++) begin
      lv = 12'($urandom);
      for (int k = 0; k < 12; k++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        send_beat(rnd128(), lv[k], w);
      end
    end
    wait_drain();
    rdy_rand = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_in128_out1536

// File: doc/in128_out1536.md
Name: in128_out1536

Overview:
- AXI-Stream width upconverter. Packs twelve 128-bit input beats into one 1536-bit output word.
- Carries a per-beat tlast vector alongside the packed word.
- Mirror of the 1536-to-128 downconverter in the data-route path. Sits on the return path from the 128-bit DMA/interconnect side into the 1536-bit systolic-array side.
- A round trip through downconverter then upconverter must be bit-exact.

Parameters:
- IN_W, 128, input beat width in bits.
- RATIO, 12, input beats per output word; output width = IN_W*RATIO = 1536.
- FLUSH_ON_LAST, 0, if 1 an input beat with tlast closes the current word early, with unused upper lanes zero-filled.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_axis_tdata  input  128  input beat data.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tready  output  1  input beat accepted when tvalid&tready.
- s_axis_tlast  input  1  input beat last flag.
- m_axis_tdata  output  1536  packed word; beat k in bits [128k+127:128k].
- m_axis_tvalid  output  1  packed word valid.
- m_axis_tready  input  1  downstream accept.
- m_axis_tlast  output  12  bit k = tlast of beat k.

Behaviour:
- Reset (rst=1 at a clk edge):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - Beat counter cnt=0, accumulator and tlast accumulator cleared.
  - s_axis_tready=1 from the first cycle after reset.
  - Reset mid-word discards all partial beats; nothing is emitted.
- Storage: one accumulation stage (acc 1536b, acc_last 12b, cnt 4b, range 0..RATIO-1) plus one output register stage (m_axis_*).
- Input accept (s_axis_tvalid & s_axis_tready):
  - Beat written into lane cnt of acc, i.e. acc[128*cnt +: 128].
  - acc_last[cnt] <= s_axis_tlast.
- Closing beat: a beat is closing if cnt==RATIO-1, or if FLUSH_ON_LAST=1 and s_axis_tlast=1.
  - On an accepted closing beat, the full word (acc with the current beat merged, lanes above cnt zero) moves to the output register.
  - m_axis_tvalid <= 1 in the same edge, so latency is one cycle from the closing-beat handshake to m_axis_tvalid.
  - cnt <= 0 and acc/acc_last are cleared in the same edge.
- Non-closing beat: cnt <= cnt+1.
- Output slot free condition: out_free = ~m_axis_tvalid | m_axis_tready.
- s_axis_tready = ~(closing_candidate & ~out_free), where closing_candidate uses the current cnt and s_axis_tlast.
  - Non-closing beats are always accepted.
  - Allowed combinational path: s_axis_tlast/m_axis_tready -> s_axis_tready. Nothing else.
- Output handshake:
  - m_axis_tvalid & m_axis_tready clears m_axis_tvalid the next edge, unless a closing beat loads the output in the same edge; then it stays 1 with the new data.
  - Sustained throughput is 12 input beats per output word with no bubbles while m_axis_tready=1.
- Output stability: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast hold.
- FLUSH_ON_LAST=0: tlast is recorded per lane only, never closes early. A tlast at beat 5 yields m_axis_tlast=12'b0000_0010_0000.
- Input idle (s_axis_tvalid=0): acc and cnt hold indefinitely, with no timeout.

Decomposition:
- Shared package data_route_pkg:
  - constants AXIS_NARROW_W=128, AXIS_WIDE_W=1536, AXIS_RATIO=12.
  - beat-count width localparam $clog2(RATIO).
  - Reused by the downconverter.
- Optional sub-module axis_reg_slice (output register stage, parameterised width). Natural here because the downconverter's output could reuse it.
- Otherwise the block is a single module.

Test Plan:
- Beats data=0..11 (lane value = beat index replicated), tlast only on beat 11, m_axis_tready=1 -> one word with lane k = k, m_axis_tlast=12'h800, m_axis_tvalid high exactly one cycle after beat 11's handshake.
- 36 back-to-back beats, continuous tvalid and tready -> three words on cycles 12, 24, 36 after the first accept; s_axis_tready never deasserts.
- m_axis_tready=0 after the first word, then 11 more beats -> all 11 accepted, the 12th stalls (s_axis_tready=0) until m_axis_tready=1. The first word holds stable throughout. The second word is correct after release.
- rst=1 after 7 beats, then 12 fresh beats 0xA..0xA -> the single output word is all 0xA lanes; no beats from before reset appear.
- FLUSH_ON_LAST=1, 5 beats with tlast on beat 4 -> word with lanes 0..4 = data, lanes 5..11 = 0, m_axis_tlast=12'h010, cnt back to 0.
- Loopback: 1536-to-128 downconverter feeding this block, 100 random words with random tvalid/tready gaps -> output identical to the input words, including the tlast vector.
